md_ctrl: RTL

//  Sequencer for the multiply/divide unit. Accepts HI/LO-class instructions

---
 rtl/md_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multiply/divide sequencer: operand latch, latency count, HI/LO commit, D-stage stall
module md_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_op_valid,
    input  logic [2:0]  e_op,
    input  logic        e_cancel,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_is_md,
    output logic [1:0]  dp_op,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    input  logic [31:0] dp_hi,
    input  logic [31:0] dp_lo,
    output logic        start,
    output logic        busy,
    output logic        stall_d,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             e_accept;
    logic             mt_hi;
    logic             mt_lo;
    logic [CNT_W-1:0] run_lat;
    logic             div_by_zero;

    // E-stage ops are only honoured while the unit is idle; cancel kills them for this cycle only.
    assign e_accept    = (state == IDLE) && e_op_valid && !e_cancel;
    assign start       = e_accept && !e_op[2];
    assign mt_hi       = e_accept && (e_op == 3'd4);
    assign mt_lo       = e_accept && (e_op == 3'd5);
    assign stall_d     = d_is_md && (busy || start);

    // dp_op[1] distinguishes DIV/DIVU from MULT/MULTU.
    assign run_lat     = dp_op[1] ? DIV_LAT_C : MULT_LAT_C;
    assign div_by_zero = dp_op[1] && (dp_b == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            dp_op <= 2'd0;
            dp_a  <= 32'd0;
            dp_b  <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dp_op <= e_op[1:0];
                        dp_a  <= e_rs;
                        dp_b  <= e_rt;
                        count <= CNT_ONE;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (mt_hi) begin
                        hi <= e_rs;
                    end else if (mt_lo) begin
                        lo <= e_rs;
                    end
                end
                RUN: begin
                    if (count == run_lat) begin
                        // Divide by zero leaves HI/LO untouched but keeps the normal handshake timing.
                        if (!div_by_zero) begin
                            hi <= dp_hi;
                            lo <= dp_lo;
                        end
                        busy  <= 1'b0;
                        count <= '0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
